// File: rtl/prbs_pattern_engine.sv
// prbs_pattern_engine: loads a PAT_BYTES-beat pattern, replays it n_repeats times, then streams PRBS.
// Rev 1.0 -- parametrised data width, pattern length and PRBS order; loopback repeat checker.
`default_nettype none

module prbs_pattern_engine #(
  parameter int DATA_W     = 8,
  parameter int PAT_BYTES  = 4,
  parameter int PRBS_ORDER = 15,
  parameter int CNT_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  input  logic [CNT_W-1:0]  n_repeats,
  input  logic              start,
  input  logic              stop,
  input  logic              clear,
  output logic              gen_valid,
  output logic [DATA_W-1:0] gen_data,
  input  logic              chk_valid,
  input  logic [DATA_W-1:0] chk_data,
  output logic              busy,
  output logic              pattern_found
);

  localparam int PAT_W  = DATA_W * PAT_BYTES;
  localparam int IDX_W  = (PAT_BYTES > 1) ? $clog2(PAT_BYTES) : 1;
  localparam int FILL_W = $clog2(PAT_BYTES + 1);
  localparam int TAP    = (PRBS_ORDER == 7)  ? 6  :
                          (PRBS_ORDER == 15) ? 14 :
                          (PRBS_ORDER == 23) ? 18 :
                          (PRBS_ORDER == 31) ? 28 : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(PAT_BYTES - 1);
  localparam logic [FILL_W-1:0] FULL     = FILL_W'(PAT_BYTES);

  generate
    if (PRBS_ORDER != 7 && PRBS_ORDER != 15 && PRBS_ORDER != 23 && PRBS_ORDER != 31) begin : g_bad_order
      $error("prbs_pattern_engine: PRBS_ORDER must be 7, 15, 23 or 31");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_ARMED   = 3'd2,
    S_PATTERN = 3'd3,
    S_PRBS    = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [PAT_W-1:0]      pattern;
  logic [IDX_W-1:0]      load_cnt;
  logic [IDX_W-1:0]      idx;
  logic [CNT_W-1:0]      rep_left;
  logic [CNT_W-1:0]      nrep_lat;
  logic [PRBS_ORDER-1:0] lfsr;
  logic [PRBS_ORDER-1:0] lfsr_adv;
  logic [DATA_W-1:0]     prbs_byte;

  logic load_fire, last_load, start_ok, pat_last;

  assign load_ready = (state == S_IDLE) || (state == S_LOAD);
  assign busy       = (state == S_PATTERN) || (state == S_PRBS);
  assign gen_valid  = busy;
  assign load_fire  = load_valid && load_ready && !clear;
  assign last_load  = (load_cnt == LAST_IDX);
  assign start_ok   = (state == S_ARMED) && start && !clear;
  assign pat_last   = (idx == LAST_IDX) && (rep_left == CNT_W'(1));

  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:    if (load_fire) state_nxt = last_load ? S_ARMED : S_LOAD;
        S_LOAD:    if (load_fire && last_load) state_nxt = S_ARMED;
        S_ARMED:   if (start) state_nxt = (n_repeats != '0) ? S_PATTERN : S_PRBS;
        S_PATTERN: begin
          if (stop)          state_nxt = S_ARMED;
          else if (pat_last) state_nxt = S_PRBS;
        end
        S_PRBS:    if (stop) state_nxt = S_ARMED;
        default:   state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Output byte is the next DATA_W LFSR bits, earliest bit in the MSB.
  always_comb begin
    logic [PRBS_ORDER-1:0] s;
    logic                  fb;
    s         = lfsr;
    fb        = 1'b0;
    prbs_byte = '0;
    for (int i = 0; i < DATA_W; i++) begin
      fb                    = s[PRBS_ORDER-1] ^ s[TAP-1];
      prbs_byte[DATA_W-1-i] = fb;
      s                     = {s[PRBS_ORDER-2:0], fb};
    end
    lfsr_adv = s;
  end

  always_comb begin
    gen_data = '0;
    case (state)
      S_PATTERN: gen_data = pattern[(PAT_BYTES-1-int'(idx))*DATA_W +: DATA_W];
      S_PRBS:    gen_data = prbs_byte;
      default:   gen_data = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pattern  <= '0;
      load_cnt <= '0;
      idx      <= '0;
      rep_left <= '0;
      nrep_lat <= '0;
      lfsr     <= '1;
    end else begin
      if (clear) begin
        pattern  <= '0;
        load_cnt <= '0;
        nrep_lat <= '0;
      end else if (load_fire) begin
        pattern  <= (pattern << DATA_W) | PAT_W'(load_data);
        load_cnt <= last_load ? '0 : load_cnt + IDX_W'(1);
      end

      if (start_ok) begin
        idx      <= '0;
        rep_left <= n_repeats;
        nrep_lat <= n_repeats;
      end else if (state == S_PATTERN) begin
        idx <= (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
        if (idx == LAST_IDX) rep_left <= rep_left - CNT_W'(1);
      end

      // Reseed whenever PRBS is (re)entered; only advance while staying in PRBS.
      if (state == S_PRBS && state_nxt == S_PRBS) lfsr <= lfsr_adv;
      else                                        lfsr <= '1;
    end
  end

  logic [PAT_W-1:0]  window, win_shift, win_nxt;
  logic [FILL_W-1:0] fill, fill_inc, fill_nxt;
  logic [IDX_W-1:0]  grp, grp_nxt;
  logic [CNT_W-1:0]  count, count_nxt;
  logic              aligned, aligned_nxt, found_nxt, chk_clr;

  assign win_shift = (window << DATA_W) | PAT_W'(chk_data);
  assign fill_inc  = (fill == FULL) ? FULL : fill + FILL_W'(1);
  assign chk_clr   = clear || start_ok;

  always_comb begin
    win_nxt     = window;
    fill_nxt    = fill;
    grp_nxt     = grp;
    count_nxt   = count;
    aligned_nxt = aligned;
    if (chk_valid) begin
      win_nxt = win_shift;
      if (!aligned) begin
        fill_nxt = fill_inc;
        if (fill_inc == FULL && win_shift == pattern) begin
          aligned_nxt = 1'b1;
          grp_nxt     = '0;
          count_nxt   = CNT_W'(1);
        end
      end else begin
        grp_nxt = (grp == LAST_IDX) ? '0 : grp + IDX_W'(1);
        if (grp == LAST_IDX) begin
          if (win_shift == pattern) begin
            count_nxt = (count == '1) ? count : count + CNT_W'(1);
          end else begin
            // Restart the search with the failing beat as the oldest window entry.
            count_nxt   = '0;
            aligned_nxt = 1'b0;
            fill_nxt    = FILL_W'(1);
          end
        end
      end
    end
    found_nxt = pattern_found || ((nrep_lat != '0) && (count_nxt == nrep_lat));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      window        <= '0;
      fill          <= '0;
      grp           <= '0;
      count         <= '0;
      aligned       <= 1'b0;
      pattern_found <= 1'b0;
    end else if (chk_clr) begin
      window        <= '0;
      fill          <= '0;
      grp           <= '0;
      count         <= '0;
      aligned       <= 1'b0;
      pattern_found <= 1'b0;
    end else begin
      window        <= win_nxt;
      fill          <= fill_nxt;
      grp           <= grp_nxt;
      count         <= count_nxt;
      aligned       <= aligned_nxt;
      pattern_found <= found_nxt;
    end
  end

endmodule

`default_nettype wire
